// File: rtl/shift_register_universal.sv
// -----------------------------------------------------------------------------
// shift_register_universal
//
// DEPTH stages of WIDTH bits each. The register can hold, shift right, shift
// left, rotate right, rotate left, parallel load and clear. A saturating shift
// counter and a frame-complete flag show when DEPTH shifts have happened since
// the last load, clear or reset. Each WIDTH-bit lane always moves as one unit.
//
// Ports
//   clock    in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   mode     in   [2:0] operation select, sampled on each rising edge
//   sin_l    in   [WIDTH-1:0] serial input into stage 0 (shift right)
//   sin_r    in   [WIDTH-1:0] serial input into stage DEPTH-1 (shift left)
//   pdin     in   [WIDTH*DEPTH-1:0] parallel load data, stage i at i*WIDTH
//   q        out  [WIDTH*DEPTH-1:0] register contents, stage i at i*WIDTH
//   sout_r   out  [WIDTH-1:0] stage DEPTH-1
//   sout_l   out  [WIDTH-1:0] stage 0
//   count    out  [CW-1:0] shifts since last load/clear, saturates at DEPTH
//   full     out  count == DEPTH
// -----------------------------------------------------------------------------
module shift_register_universal #(
  parameter  int WIDTH = 1,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [2:0]             mode,
  input  logic [WIDTH-1:0]       sin_l,
  input  logic [WIDTH-1:0]       sin_r,
  input  logic [WIDTH*DEPTH-1:0] pdin,
  output logic [WIDTH*DEPTH-1:0] q,
  output logic [WIDTH-1:0]       sout_r,
  output logic [WIDTH-1:0]       sout_l,
  output logic [CW-1:0]          count,
  output logic                   full
);

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_SHR   = 3'b001,
    MODE_SHL   = 3'b010,
    MODE_ROR   = 3'b011,
    MODE_ROL   = 3'b100,
    MODE_LOAD  = 3'b101,
    MODE_CLEAR = 3'b110,
    MODE_RSVD  = 3'b111
  } mode_t;

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  // The packed 2-D layout puts stage i at bits [i*WIDTH +: WIDTH], so the
  // flat q and pdin buses map onto it without any reshuffling.
  logic [DEPTH-1:0][WIDTH-1:0] stage;
  logic [DEPTH-1:0][WIDTH-1:0] stage_nxt;
  logic [CW-1:0]               count_nxt;
  logic                        bump;
  logic                        restart;
  mode_t                       mode_e;

  assign mode_e = mode_t'(mode);

  // Next-state selection for the data lanes and the counter. Right means
  // toward higher stage numbers and left toward stage 0. With DEPTH = 1 the
  // inner loops are empty: a rotate keeps the single stage and a shift takes
  // the serial input.
  always_comb begin
    stage_nxt = stage;
    bump      = 1'b0;
    restart   = 1'b0;
    case (mode_e)
      MODE_SHR: begin
        for (int i = 1; i < DEPTH; i++) stage_nxt[i] = stage[i-1];
        stage_nxt[0] = sin_l;
        bump         = 1'b1;
      end
      MODE_SHL: begin
        for (int i = 0; i < DEPTH - 1; i++) stage_nxt[i] = stage[i+1];
        stage_nxt[DEPTH-1] = sin_r;
        bump               = 1'b1;
      end
      MODE_ROR: begin
        for (int i = 1; i < DEPTH; i++) stage_nxt[i] = stage[i-1];
        stage_nxt[0] = stage[DEPTH-1];
        bump         = 1'b1;
      end
      MODE_ROL: begin
        for (int i = 0; i < DEPTH - 1; i++) stage_nxt[i] = stage[i+1];
        stage_nxt[DEPTH-1] = stage[0];
        bump               = 1'b1;
      end
      MODE_LOAD: begin
        stage_nxt = pdin;
        restart   = 1'b1;
      end
      MODE_CLEAR: begin
        stage_nxt = '0;
        restart   = 1'b1;
      end
      default: begin
        stage_nxt = stage;
      end
    endcase

    // The counter saturates at DEPTH. Data keeps moving after that point.
    count_nxt = count;
    if (restart) begin
      count_nxt = '0;
    end else if (bump && (count != FULL_COUNT)) begin
      count_nxt = count + 1'b1;
    end
  end

  // full is registered from the next count, so every output comes straight
  // from a flop.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stage <= '0;
      count <= '0;
      full  <= 1'b0;
    end else begin
      stage <= stage_nxt;
      count <= count_nxt;
      full  <= (count_nxt == FULL_COUNT);
    end
  end

  assign q      = stage;
  assign sout_l = stage[0];
  assign sout_r = stage[DEPTH-1];

endmodule

// File: tb/tb_shift_register_universal.sv
// -----------------------------------------------------------------------------
// tb_shift_register_universal
//
// Drives four shift_register_universal instances from one shared mode and
// reset: A (W1,D4), B (W4,D4), C (W1,D8) and D (W3,D1). Each instance has its
// own serial and parallel inputs. The reference model treats each register as
// one integer. Shifts and rotates are multiplications or divisions by 2^WIDTH,
// with the value masked to WIDTH*DEPTH bits.
// -----------------------------------------------------------------------------
module tb_shift_register_universal;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [2:0] mode;

  logic [63:0] slv [4];
  logic [63:0] srv [4];
  logic [63:0] pdv [4];

  logic [3:0]  qa;  logic       sla, sra; logic [2:0] ca; logic fa;
  logic [15:0] qb;  logic [3:0] slb, srb; logic [2:0] cb; logic fb;
  logic [7:0]  qc;  logic       slc, src; logic [3:0] cc; logic fc;
  logic [2:0]  qd;  logic [2:0] sld, srd; logic [0:0] cd; logic fd;

  logic [63:0] mv [4];
  int          mc [4];
  int          passed = 0;
  int          total  = 0;

  always #5 clock = ~clock;

  shift_register_universal #(.WIDTH(1), .DEPTH(4)) dut_a (
    .clock(clock), .reset_n(reset_n), .mode(mode),
    .sin_l(slv[0][0:0]), .sin_r(srv[0][0:0]), .pdin(pdv[0][3:0]),
    .q(qa), .sout_r(sra), .sout_l(sla), .count(ca), .full(fa));

  shift_register_universal #(.WIDTH(4), .DEPTH(4)) dut_b (
    .clock(clock), .reset_n(reset_n), .mode(mode),
    .sin_l(slv[1][3:0]), .sin_r(srv[1][3:0]), .pdin(pdv[1][15:0]),
    .q(qb), .sout_r(srb), .sout_l(slb), .count(cb), .full(fb));

  shift_register_universal #(.WIDTH(1), .DEPTH(8)) dut_c (
    .clock(clock), .reset_n(reset_n), .mode(mode),
    .sin_l(slv[2][0:0]), .sin_r(srv[2][0:0]), .pdin(pdv[2][7:0]),
    .q(qc), .sout_r(src), .sout_l(slc), .count(cc), .full(fc));

  shift_register_universal #(.WIDTH(3), .DEPTH(1)) dut_d (
    .clock(clock), .reset_n(reset_n), .mode(mode),
    .sin_l(slv[3][2:0]), .sin_r(srv[3][2:0]), .pdin(pdv[3][2:0]),
    .q(qd), .sout_r(srd), .sout_l(sld), .count(cd), .full(fd));

  // Instance geometry, indexed as in the model arrays.
  function automatic int laneW(input int k);
    case (k)
      1:       return 4;
      3:       return 3;
      default: return 1;
    endcase
  endfunction

  function automatic int laneD(input int k);
    case (k)
      2:       return 8;
      3:       return 1;
      default: return 4;
    endcase
  endfunction

  // The register is one integer whose lowest lane is stage 0. Shifting right
  // multiplies by 2^w and adds the new lane. Shifting left divides by 2^w and
  // places the new lane on top.
  function automatic logic [63:0] modelData(input int k, input logic [2:0] m,
                                            input logic [63:0] v, sl, sr, pd);
    int          w   = laneW(k);
    int          d   = laneD(k);
    int          top = w * (d - 1);
    logic [63:0] lm  = (64'd1 << w) - 64'd1;
    logic [63:0] fm  = (64'd1 << (w * d)) - 64'd1;
    case (m)
      3'd1:    return ((v << w) | (sl & lm)) & fm;
      3'd2:    return (v >> w) | ((sr & lm) << top);
      3'd3:    return ((v << w) | (v >> top)) & fm;
      3'd4:    return (v >> w) | ((v & lm) << top);
      3'd5:    return pd & fm;
      3'd6:    return 64'd0;
      default: return v;
    endcase
  endfunction

  function automatic int modelCount(input int k, input logic [2:0] m, input int c);
    int d = laneD(k);
    case (m)
      3'd1, 3'd2, 3'd3, 3'd4: return (c < d) ? c + 1 : d;
      3'd5, 3'd6:             return 0;
      default:                return c;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic checkInst(input string name, input int k, input logic [63:0] q,
                           input logic [63:0] sl, input logic [63:0] sr,
                           input logic [63:0] cnt, input logic f);
    int          w  = laneW(k);
    int          d  = laneD(k);
    logic [63:0] lm = (64'd1 << w) - 64'd1;
    checkOutput({name, "_q"},      q,   mv[k]);
    checkOutput({name, "_sout_l"}, sl,  mv[k] & lm);
    checkOutput({name, "_sout_r"}, sr,  (mv[k] >> (w * (d - 1))) & lm);
    checkOutput({name, "_count"},  cnt, 64'(mc[k]));
    checkOutput({name, "_full"},   64'(f), 64'(mc[k] == d));
  endtask

  task automatic checkAll();
    checkInst("a", 0, 64'(qa), 64'(sla), 64'(sra), 64'(ca), fa);
    checkInst("b", 1, 64'(qb), 64'(slb), 64'(srb), 64'(cb), fb);
    checkInst("c", 2, 64'(qc), 64'(slc), 64'(src), 64'(cc), fc);
    checkInst("d", 3, 64'(qd), 64'(sld), 64'(srd), 64'(cd), fd);
  endtask

  task automatic randomInputs();
    for (int k = 0; k < 4; k++) begin
      slv[k] = {$urandom, $urandom};
      srv[k] = {$urandom, $urandom};
      pdv[k] = {$urandom, $urandom};
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < 4; k++) begin
      mv[k] = 64'd0;
      mc[k] = 0;
    end
  endtask

  // Present one mode for one edge, advance the model and compare everything
  // shortly after the edge.
  task automatic applyStimulus(input logic [2:0] m);
    logic [63:0] nv [4];
    int          nc [4];
    mode = m;
    for (int k = 0; k < 4; k++) begin
      nv[k] = modelData(k, m, mv[k], slv[k], srv[k], pdv[k]);
      nc[k] = modelCount(k, m, mc[k]);
    end
    @(posedge clock);
    #1;
    for (int k = 0; k < 4; k++) begin
      mv[k] = nv[k];
      mc[k] = nc[k];
    end
    checkAll();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired before the sequence finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    $display("[TB] start");
    reset_n = 1'b0;
    mode    = 3'b101;
    for (int k = 0; k < 4; k++) begin
      slv[k] = '1;
      srv[k] = '1;
      pdv[k] = '1;
    end
    modelReset();

    // Reset held with a load request on the inputs: the register stays zero.
    repeat (3) begin
      @(posedge clock);
      #1;
      checkAll();
    end

    mode    = 3'b000;
    reset_n = 1'b1;
    applyStimulus(3'b000);
    checkOutput("release_q_a", 64'(qa), 64'h0);

    // A one walks from sin_l to sout_r on instance A.
    for (int i = 1; i <= 5; i++) begin
      randomInputs();
      slv[0] = (i == 1) ? 64'd1 : 64'd0;
      applyStimulus(3'b001);
      checkOutput("walk_q_a",     64'(qa), (i <= 4) ? (64'd1 << (i - 1)) : 64'd0);
      checkOutput("walk_count_a", 64'(ca), (i <= 4) ? 64'(i) : 64'd4);
      checkOutput("walk_full_a",  64'(fa), (i >= 4) ? 64'd1 : 64'd0);
      if (i == 4) checkOutput("walk_sout_r_a", 64'(sra), 64'd1);
    end

    // Load and rotate on instance B.
    randomInputs();
    pdv[1] = 64'h4321;
    applyStimulus(3'b101);
    checkOutput("load_q_b",     64'(qb), 64'h4321);
    checkOutput("load_count_b", 64'(cb), 64'd0);
    applyStimulus(3'b011);
    checkOutput("ror1_q_b", 64'(qb), 64'h3214);
    applyStimulus(3'b011);
    checkOutput("ror2_q_b",     64'(qb), 64'h2143);
    checkOutput("ror2_count_b", 64'(cb), 64'd2);
    checkOutput("ror2_full_b",  64'(fb), 64'd0);
    applyStimulus(3'b100);
    checkOutput("rol_q_b", 64'(qb), 64'h3214);

    // Shift left on instance C.
    randomInputs();
    pdv[2] = 64'hA5;
    applyStimulus(3'b101);
    checkOutput("load_q_c", 64'(qc), 64'hA5);
    srv[2] = 64'd1;
    applyStimulus(3'b010);
    checkOutput("shl_q_c",      64'(qc),  64'hD2);
    checkOutput("shl_sout_l_c", 64'(slc), 64'd0);

    // Fill A, then reserved/hold keep everything, then clear.
    repeat (4) begin
      randomInputs();
      applyStimulus(3'b001);
    end
    checkOutput("fill_full_a", 64'(fa), 64'd1);
    applyStimulus(3'b111);
    applyStimulus(3'b000);
    applyStimulus(3'b111);
    checkOutput("hold_full_a",  64'(fa), 64'd1);
    checkOutput("hold_count_a", 64'(ca), 64'd4);
    applyStimulus(3'b110);
    checkOutput("clear_q_a",     64'(qa), 64'd0);
    checkOutput("clear_count_a", 64'(ca), 64'd0);
    checkOutput("clear_full_a",  64'(fa), 64'd0);
    checkOutput("clear_q_b",     64'(qb), 64'd0);

    // Reset in the middle of a frame, between edges.
    repeat (2) begin
      randomInputs();
      applyStimulus(3'b001);
    end
    reset_n = 1'b0;
    #2;
    modelReset();
    checkOutput("midrst_q_a",     64'(qa), 64'd0);
    checkOutput("midrst_count_a", 64'(ca), 64'd0);
    checkOutput("midrst_full_a",  64'(fa), 64'd0);
    checkAll();
    #1;
    reset_n = 1'b1;
    applyStimulus(3'b001);
    checkOutput("midrst_next_count_a", 64'(ca), 64'd1);

    // Random operation mix, with the occasional asynchronous reset pulse.
    for (int n = 0; n < 300; n++) begin
      randomInputs();
      if ($urandom_range(0, 39) == 0) begin
        reset_n = 1'b0;
        #2;
        modelReset();
        checkAll();
        reset_n = 1'b1;
      end
      applyStimulus(3'($urandom_range(0, 7)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
